sd_spi_master: RTL

- Byte-level SPI initiator (mode 0, MSB first) that drives an SD/MMC card over SCK/MOSI/MISO/SS.
- Its outputs can be routed either to the physical SD pins or to the virtual sd_card responder through the same vsd_sel muxing used in the top level.
- A CPU-side or ROM-loader controller issues one byte exchange at a time through a start/busy/done handshake.
- Serves both the init phase (slow clock, SS high, dummy clocks) and the data phase (fast clock).

---
 rtl/sd_spi_master.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-level SPI mode-0 initiator (MSB first) for SD/MMC cards.
// Define SD_SPI_CRC7_EN to enable the CRC7 accumulator of transmitted bits.
module sd_spi_master #(
  parameter int DIV_W     = 8,
  parameter bit IDLE_MOSI = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             ss_req,
  input  logic             start,
  input  logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_data,
  output logic             sck,
  output logic             mosi,
  input  logic             miso,
  output logic             ss,
  input  logic             crc_clr,
  output logic [6:0]       crc7
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic [7:0]       rx_next;
  logic             miso_q;
  logic             phase_end;
  logic             last_bit;

  assign phase_end = (cnt == div_q);
  assign last_bit  = (bit_cnt == 3'd7);

  // miso_q is one cycle late, so it is shifted in on the first HIGH cycle:
  // that captures the miso level of the cycle just before sck rose.
  assign rx_next = (cnt == '0) ? {rx_sr[6:0], miso_q} : rx_sr;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOW;
      S_LOW:   if (phase_end) state_next = S_HIGH;
      S_HIGH:  if (phase_end) state_next = last_bit ? S_IDLE : S_LOW;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    sck  = (state == S_HIGH);
    mosi = (state == S_IDLE) ? IDLE_MOSI : tx_sr[7];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q   <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      done    <= 1'b0;
      ss      <= 1'b1;
      miso_q  <= 1'b0;
    end else begin
      miso_q <= miso;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          // ss only follows the request between bytes, never mid-byte.
          ss      <= ss_req;
          cnt     <= '0;
          bit_cnt <= '0;
          if (start) begin
            tx_sr <= tx_data;
            div_q <= clk_div;
          end
        end
        S_LOW: begin
          if (phase_end) cnt <= '0;
          else           cnt <= cnt + DIV_W'(1);
        end
        S_HIGH: begin
          rx_sr <= rx_next;
          if (phase_end) begin
            cnt     <= '0;
            tx_sr   <= {tx_sr[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              done    <= 1'b1;
              rx_data <= rx_next;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SD_SPI_CRC7_EN
  logic rise;
  logic crc_fb;

  assign rise   = (state == S_LOW) && phase_end;
  assign crc_fb = crc7[6] ^ tx_sr[7];

  // x^7 + x^3 + 1, one step per transmitted bit at the rising sck edge.
  always_ff @(posedge clk_sys) begin
    if (reset || crc_clr) crc7 <= '0;
    else if (rise)        crc7 <= {crc7[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
  end
`else
  logic crc_clr_unused;

  assign crc_clr_unused = crc_clr;
  assign crc7           = '0;
`endif

endmodule
